// File: rtl/rst_seq_sync_if.sv
// rst_seq_sync_if: soft-reset request in, sequenced active-low resets and ready flag out.
interface rst_seq_sync_if #(
    parameter int NUM_OUT = 3
);
    logic               sw_rst;
    logic [NUM_OUT-1:0] rst_out_n;
    logic               rdy;
    modport master (output sw_rst, input rst_out_n, rdy);
    modport slave (input sw_rst, output rst_out_n, rdy);
endinterface

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: async-assert, sync-release reset sequencer with staggered per-domain release.
module rst_seq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_OUT     = 3,
    parameter int STAGGER     = 2
) (
    input logic           clk,
    input logic           rst_n,
    rst_seq_sync_if.slave bus
);
    localparam int CMAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {RESET, HOLD, RELEASE, DONE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_OUT-1:0]     out_q, out_d;
    logic                   rdy_q;
    logic                   rst_req;

    assign rst_req       = !sync_q[SYNC_STAGES-1] || bus.sw_rst;
    assign bus.rst_out_n = out_q;
    assign bus.rdy       = rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= RESET;
            cnt_q   <= '0;
            out_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            rdy_q   <= &out_d;
        end
    end

    // Release shifts a 1 in from bit 0, so bit i can never precede bit i-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        if (rst_req) begin
            state_d = RESET;
            cnt_d   = '0;
            out_d   = '0;
        end else begin
            case (state_q)
                RESET: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
                HOLD: begin
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        out_d   = NUM_OUT'(1);
                        cnt_d   = '0;
                        state_d = (NUM_OUT == 1) ? DONE : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                RELEASE: begin
                    if (cnt_q == CW'(STAGGER - 1)) begin
                        out_d   = (out_q << 1) | NUM_OUT'(1);
                        cnt_d   = '0;
                        state_d = (&out_d) ? DONE : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DONE: state_d = DONE;
                default: state_d = RESET;
            endcase
        end
    end
endmodule
